fir_output_requant: RTL
=======================

// Module: fir_output_requant
// PURPOSE
//   Sink side of the fir_filter datapath. Takes the 32-bit signed filter output,
//   discards pipeline-fill samples after reset, rounds and saturates each sample
//   to 16 bits, and buffers the results in a small FIFO. The FIFO drains over a
//   valid/ready handshake to downstream logic (DAC driver, capture RAM).
// PARAMETERS
//   IN_W   32  input sample width (signed, two's complement)
//   OUT_W  16  output sample width (signed)
//   SHIFT  15  arithmetic right shift applied after rounding (Q15 coefficient scaling)
//   SKIP   8   number of accepted input samples discarded after reset/clear (fill latency)
//   DEPTH  8   FIFO depth in entries; power of two, >= 2
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       asynchronous, active-low reset (rst==0 resets)
//   clr        in   1       synchronous clear: empty FIFO, return to SETTLE
//   in_valid   in   1       in_data holds a filter output sample this cycle
//   in_data    in   IN_W    signed filter output
//   out_valid  out  1       FIFO head is valid
//   out_ready  in   1       downstream accepts the head this cycle
//   out_data   out  OUT_W   signed requantised sample (FIFO head)
//   level      out  log2(DEPTH)+1  current FIFO occupancy
//   drop       out  1       1-cycle pulse: sample lost because FIFO was full
//   sat_seen   out  1       sticky: at least one sample saturated since reset/clr
//   ovf_seen   out  1       sticky: at least one drop since reset/clr
// BEHAVIOUR
//   Reset (rst==0, async): all outputs 0, state=SETTLE, skip counter 0, FIFO empty.
//   FSM: SETTLE -> RUN once SKIP in_valid samples have been counted. In SETTLE,
//     samples are counted and discarded and nothing reaches stage 1. In RUN, every
//     in_valid sample is processed. With SKIP=0, the FSM enters RUN right after reset.
//   clr: FIFO empties, stickies clear, skip count resets, state=SETTLE next cycle.
//     clr has priority over simultaneous push/pop.
//   Arithmetic (stage 1, registered):
//     t = in_data + 2^(SHIFT-1), computed in IN_W+1 bits (round half up).
//     q = t >>> SHIFT.
//     If q > 2^(OUT_W-1)-1, out = 2^(OUT_W-1)-1. If q < -2^(OUT_W-1), out = -2^(OUT_W-1).
//     Otherwise out = q[OUT_W-1:0]. Any clamp sets sat_seen.
//   Latency: in_valid at edge N -> stage-1 register at edge N -> FIFO write at
//     edge N+1. With an empty FIFO, out_valid=1 after edge N+1 (2 cycles).
//   Throughput: 1 sample/cycle sustained when out_ready is held high.
//   FIFO is first-word fall-through:
//     - out_data equals the head whenever out_valid=1.
//     - The head is popped on an edge where out_valid & out_ready.
//     - out_data holds its last value when empty (0 after reset).
//   Full: a stage-1 write with level==DEPTH and no pop that cycle is dropped.
//     drop pulses and ovf_seen sets. A push and pop in the same cycle when full
//     does not drop, and level stays DEPTH.
//   Empty: a pop is impossible (out_valid=0). A push and pop while level==0 cannot
//     occur, because the write becomes visible one cycle later.
//   Pointers wrap modulo DEPTH. level never exceeds DEPTH and never goes below 0.
//   Reset mid-stream: the in-flight stage-1 sample and all FIFO contents are lost.
// TESTING
//   1 Reset, SKIP=8: 8 in_valid samples of 0x00010000 -> no out_valid;
//     9th sample -> out_valid 2 cycles later with out_data=2.
//   2 Rounding: in 0x00004000 -> 1; 0xFFFFC000 -> 0; 0x3FFF0001 -> 32766;
//     0xC0000000 -> -32768 with sat_seen=0.
//   3 Saturation: in 0x40000000 -> 32767; 0xBFFF7FFF -> -32768; sat_seen=1 after first.
//   4 Backpressure: out_ready=0, 10 samples streamed -> level=8, drop pulses on
//     the 9th and 10th writes, ovf_seen=1; then out_ready=1 -> first 8 samples
//     drain in order.
//   5 Full push+pop: level=8, out_ready=1 with in_valid every cycle ->
//     no drop, level stays 8, order preserved.
//   6 Async reset asserted mid-stream (between edges) -> outputs 0 immediately,
//     SETTLE re-entered, next 8 samples discarded. clr gives the same result
//     synchronously.

Source files
------------

// File: rtl/fir_output_requant.sv
// fir_output_requant: sink side of the FIR datapath.
// Drops fill samples, rounds/saturates to OUT_W and buffers in a FWFT FIFO.
module fir_output_requant #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int SKIP  = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop,
    output logic                     sat_seen,
    output logic                     ovf_seen
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

    localparam logic ST_SETTLE = 1'b0;
    localparam logic ST_RUN    = 1'b1;
    localparam logic ST_INIT   = (SKIP == 0) ? ST_RUN : ST_SETTLE;

    localparam logic signed [IN_W:0] HALF = (IN_W + 1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAXV = (IN_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] MINV = -MAXV - (IN_W + 1)'(1);

    logic              state;
    logic [CW-1:0]     skip_cnt;
    logic              take;

    logic signed [IN_W:0] t;
    logic signed [IN_W:0] q;
    logic [OUT_W-1:0]  sat_val;
    logic              clamp;

    logic              s1_valid;
    logic [OUT_W-1:0]  s1_data;

    logic [OUT_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [OUT_W-1:0]  last_q;
    logic              full;
    logic              pop;
    logic              wr;

    assign take = in_valid & (state == ST_RUN);

    assign t = $signed({in_data[IN_W-1], in_data}) + HALF;
    assign q = t >>> SHIFT;

    // Clamp the shifted value into the signed OUT_W range.
    always_comb begin
        clamp   = 1'b0;
        sat_val = q[OUT_W-1:0];
        if (q > MAXV) begin
            clamp   = 1'b1;
            sat_val = MAXV[OUT_W-1:0];
        end else if (q < MINV) begin
            clamp   = 1'b1;
            sat_val = MINV[OUT_W-1:0];
        end
    end

    // Count and discard pipeline-fill samples before entering RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_INIT;
            skip_cnt <= '0;
        end else if (clr) begin
            state    <= ST_INIT;
            skip_cnt <= '0;
        end else if (state == ST_SETTLE && in_valid) begin
            if (skip_cnt == CW'(SKIP - 1)) begin
                state    <= ST_RUN;
                skip_cnt <= '0;
            end else begin
                skip_cnt <= skip_cnt + CW'(1);
            end
        end
    end

    // Stage 1: register the requantised sample and note any clamping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            sat_seen <= 1'b0;
        end else if (clr) begin
            s1_valid <= 1'b0;
            sat_seen <= 1'b0;
        end else begin
            s1_valid <= take;
            if (take) begin
                s1_data <= sat_val;
            end
            if (take && clamp) begin
                sat_seen <= 1'b1;
            end
        end
    end

    assign out_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign pop       = out_valid & out_ready;
    assign wr        = s1_valid & (~full | pop);
    assign out_data  = out_valid ? mem[rptr] : last_q;

    // FIFO storage; a full FIFO only accepts a write alongside a pop.
    always_ff @(posedge clk) begin
        if (wr && !clr) begin
            mem[wptr] <= s1_data;
        end
    end

    // FIFO pointers, occupancy, last-head hold and overflow flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            last_q   <= '0;
            drop     <= 1'b0;
            ovf_seen <= 1'b0;
        end else if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            drop     <= 1'b0;
            ovf_seen <= 1'b0;
        end else begin
            if (wr) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr   <= rptr + AW'(1);
                last_q <= mem[rptr];
            end
            unique case ({wr, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            drop <= s1_valid & ~wr;
            if (s1_valid && !wr) begin
                ovf_seen <= 1'b1;
            end
        end
    end

endmodule
